eth_rx_fcs_check: RTL and testbench
===================================

ETH_RX_FCS_CHECK -- requirements
Module: eth_rx_fcs_check

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64: minimum legal frame length in bytes, destination address through FCS.
REQ-002 SHALL have parameter MAX_LEN, default 1518: maximum legal frame length in bytes, destination address through FCS.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port IN_DV, input, 1 bit: receive data valid, one nibble per CLK while high.
REQ-006 SHALL have port IN_DATA, input, 4 bits: received nibble, low nibble of each byte first, bit 0 first on the wire.
REQ-007 SHALL have port OUT_SOF, output, 1 bit: one-cycle pulse when SFD is accepted.
REQ-008 SHALL have port OUT_VALID, output, 1 bit: OUT_DATA holds a completed byte this cycle.
REQ-009 SHALL have port OUT_DATA, output, 8 bits: assembled byte, {high nibble, low nibble}; FCS bytes included.
REQ-010 SHALL have port OUT_EOF, output, 1 bit: one-cycle frame-end status pulse.
REQ-011 SHALL have port OUT_FCS_OK, output, 1 bit: CRC residue matched; valid while OUT_EOF is high.
REQ-012 SHALL have port OUT_ALIGN_ERR, output, 1 bit: odd nibble count in DATA; valid while OUT_EOF is high.
REQ-013 SHALL have port OUT_LEN_ERR, output, 1 bit: length outside MIN_LEN..MAX_LEN; valid while OUT_EOF is high.
REQ-014 SHALL have port OUT_LEN, output, 11 bits: byte count of the frame; valid while OUT_EOF is high.

Function
REQ-015 SHALL implement states IDLE, PREAMBLE, DATA and DROP, all registered.
REQ-016 SHALL go IDLE->PREAMBLE on IN_DV=1 with IN_DATA=4'h5, and IDLE->DROP on IN_DV=1 with any other nibble.
REQ-017 SHALL, in PREAMBLE, stay on 4'h5, go to DATA on 4'hD if at least 1 preamble nibble was seen (pulse OUT_SOF next cycle), go to DROP on any other nibble, and go to IDLE with no outputs if IN_DV falls.
REQ-018 SHALL, in DROP, ignore input until IN_DV=0, then go to IDLE without asserting OUT_EOF.
REQ-019 SHALL, on entering DATA, load the CRC register with 32'hFFFFFFFF, polynomial 32'h04C11DB7, shifting MSB-first with no output inversion.
REQ-020 SHALL, per DATA nibble, feed IN_DATA into the CRC in bit order IN_DATA[0], [1], [2], [3].
REQ-021 SHALL latch the low nibble on even nibble index, and on odd index assert OUT_VALID with the byte and increment the byte count on the next cycle (byte latency: 1 CLK after the high nibble).
REQ-022 SHALL saturate the byte count at 11'h7FF; the count never wraps.
REQ-023 SHALL, on IN_DV falling in DATA, pulse OUT_EOF for one cycle on the next cycle and return to IDLE.
REQ-024 SHALL set OUT_FCS_OK=1 at OUT_EOF iff the CRC register equals 32'hC704DD7B.
REQ-025 SHALL set OUT_ALIGN_ERR=1 if an unpaired nibble is pending, with that nibble discarded and not counted.
REQ-026 SHALL return OUT_SOF, OUT_VALID and OUT_EOF to 0 the cycle after each pulse; the status outputs hold until the next OUT_EOF.
REQ-027 SHALL treat IN_DV=1 on the cycle immediately after OUT_EOF as a new frame evaluated from IDLE.

Reset
REQ-028 SHALL, while RESET=1, force state IDLE, CRC 32'hFFFFFFFF, byte count 0 and every output to 0.
REQ-029 SHALL, on reset asserted mid-frame, abandon the frame with no OUT_EOF, and after release ignore input until IN_DV is seen low.

Configuration
REQ-030 SHALL, with macro RX_LEN_CHECK_EN defined, set OUT_LEN_ERR=1 at OUT_EOF when OUT_LEN < MIN_LEN or OUT_LEN > MAX_LEN.
REQ-031 SHALL, with RX_LEN_CHECK_EN undefined, tie OUT_LEN_ERR to 0 and generate no comparison logic; all other behaviour is unchanged.

Verification
REQ-032 SHALL test: 15x 4'h5 then 4'hD, then a 60-byte payload with correct 4-byte FCS, then IN_DV low -> OUT_SOF once, 64 OUT_VALID bytes, OUT_EOF with OUT_LEN=64, OUT_FCS_OK=1, both error bits 0.
REQ-033 SHALL test: the same frame with one payload bit flipped -> OUT_FCS_OK=0, OUT_LEN=64.
REQ-034 SHALL test: the same frame plus one extra nibble 4'hA before IN_DV falls -> OUT_ALIGN_ERR=1, OUT_LEN=64.
REQ-035 SHALL test: preamble 4'h5 4'h5 4'h3 then more nibbles -> DROP, no OUT_SOF, no OUT_VALID, no OUT_EOF.
REQ-036 SHALL test: a 20-byte frame with RX_LEN_CHECK_EN defined -> OUT_LEN=20, OUT_LEN_ERR=1; with it undefined -> OUT_LEN_ERR=0.
REQ-037 SHALL test: RESET pulsed after byte 10 of a frame with IN_DV kept high -> outputs 0, no OUT_EOF, the next clean frame decoded correctly.

Source files
------------

// File: rtl/eth_rx_fcs_check.sv
// -----------------------------------------------------------------------------
// eth_rx_fcs_check
//
// Receives an MII-style nibble stream, strips the preamble/SFD, reassembles
// bytes (low nibble first), runs the Ethernet CRC-32 over every DATA nibble and
// reports frame status on a one-cycle end-of-frame pulse.
//
// Configuration macro:
//   RX_LEN_CHECK_EN  when defined, OUT_LEN_ERR flags frames whose byte count
//                    lies outside MIN_LEN..MAX_LEN; when undefined it is 0.
//
// Ports:
//   CLK            clock, rising edge
//   RESET          asynchronous, active-high reset
//   IN_DV          receive data valid, one nibble per cycle while high
//   IN_DATA[3:0]   received nibble, low nibble of each byte first
//   OUT_SOF        one-cycle pulse after the SFD is accepted
//   OUT_VALID      OUT_DATA holds a completed byte this cycle
//   OUT_DATA[7:0]  assembled byte {high nibble, low nibble}, FCS included
//   OUT_EOF        one-cycle frame-end pulse
//   OUT_FCS_OK     CRC residue matched            (held from OUT_EOF)
//   OUT_ALIGN_ERR  odd nibble count in DATA       (held from OUT_EOF)
//   OUT_LEN_ERR    length outside MIN_LEN..MAX_LEN (held from OUT_EOF)
//   OUT_LEN[10:0]  frame byte count, saturating   (held from OUT_EOF)
//   OUT_DBG_STATE  current FSM state (IDLE=0, PREAMBLE=1, DATA=2, DROP=3)
//
// Handshake: there is no back-pressure. A nibble is consumed on every rising
// edge where IN_DV is high; OUT_VALID/OUT_SOF/OUT_EOF are single-cycle
// qualifiers that the consumer must sample on the cycle they are high.
// -----------------------------------------------------------------------------
module eth_rx_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_DV,
  input  logic [3:0]  IN_DATA,
  output logic        OUT_SOF,
  output logic        OUT_VALID,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_EOF,
  output logic        OUT_FCS_OK,
  output logic        OUT_ALIGN_ERR,
  output logic        OUT_LEN_ERR,
  output logic [10:0] OUT_LEN,
  output logic [1:0]  OUT_DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [10:0] LEN_SAT     = 11'h7FF;

  state_t      state_q;
  logic [31:0] crc_q, crc_d;
  logic [10:0] cnt_q, cnt_d;
  logic [3:0]  low_q;
  logic        odd_q;       // a low nibble is waiting for its high nibble
  logic        wait_low_q;  // after reset, ignore the line until IN_DV drops
  logic        len_err_d;

  logic        sof_q, valid_q, eof_q, fcs_ok_q, align_q, len_err_q;
  logic [7:0]  data_q;
  logic [10:0] len_q;

  // Four serial CRC steps per nibble, bit 0 of the nibble first.
  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < 4; i++) begin
      if (crc_d[31] ^ IN_DATA[i]) crc_d = {crc_d[30:0], 1'b0} ^ CRC_POLY;
      else                        crc_d = {crc_d[30:0], 1'b0};
    end
  end

  assign cnt_d = (cnt_q == LEN_SAT) ? cnt_q : cnt_q + 11'd1;

`ifdef RX_LEN_CHECK_EN
  assign len_err_d = (cnt_q < 11'(MIN_LEN)) || (cnt_q > 11'(MAX_LEN));
`else
  // Length limits only matter when checking is compiled in.
  logic unused_len_limits;
  assign unused_len_limits = ^{MIN_LEN, MAX_LEN};
  assign len_err_d         = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      crc_q      <= CRC_INIT;
      cnt_q      <= 11'd0;
      low_q      <= 4'd0;
      odd_q      <= 1'b0;
      wait_low_q <= 1'b1;
      sof_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 8'd0;
      eof_q      <= 1'b0;
      fcs_ok_q   <= 1'b0;
      align_q    <= 1'b0;
      len_err_q  <= 1'b0;
      len_q      <= 11'd0;
    end else begin
      sof_q   <= 1'b0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wait_low_q) begin
            // A frame cut by reset must not be mistaken for a new one.
            if (!IN_DV) wait_low_q <= 1'b0;
          end else if (IN_DV) begin
            state_q <= (IN_DATA == 4'h5) ? S_PREAMBLE : S_DROP;
          end
        end
        S_PREAMBLE: begin
          if (!IN_DV) begin
            state_q <= S_IDLE;
          end else if (IN_DATA == 4'hD) begin
            state_q <= S_DATA;
            sof_q   <= 1'b1;
            crc_q   <= CRC_INIT;
            cnt_q   <= 11'd0;
            odd_q   <= 1'b0;
          end else if (IN_DATA != 4'h5) begin
            state_q <= S_DROP;
          end
        end
        S_DATA: begin
          if (IN_DV) begin
            crc_q <= crc_d;
            if (!odd_q) begin
              low_q <= IN_DATA;
              odd_q <= 1'b1;
            end else begin
              valid_q <= 1'b1;
              data_q  <= {IN_DATA, low_q};
              odd_q   <= 1'b0;
              cnt_q   <= cnt_d;
            end
          end else begin
            // A pending odd nibble is simply flagged; it was never counted.
            state_q   <= S_IDLE;
            eof_q     <= 1'b1;
            len_q     <= cnt_q;
            fcs_ok_q  <= (crc_q == CRC_RESIDUE);
            align_q   <= odd_q;
            len_err_q <= len_err_d;
            odd_q     <= 1'b0;
          end
        end
        S_DROP: begin
          if (!IN_DV) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign OUT_SOF       = sof_q;
  assign OUT_VALID     = valid_q;
  assign OUT_DATA      = data_q;
  assign OUT_EOF       = eof_q;
  assign OUT_FCS_OK    = fcs_ok_q;
  assign OUT_ALIGN_ERR = align_q;
  assign OUT_LEN_ERR   = len_err_q;
  assign OUT_LEN       = len_q;
  assign OUT_DBG_STATE = state_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// -----------------------------------------------------------------------------
// tb_eth_rx_fcs_check
//
// Frames are built from random payloads with a standard reflected CRC-32 FCS
// (little-endian byte order). Expected byte streams, lengths and FCS status
// come from that byte-level model; a negedge monitor collects what the design
// emits into queues that each scenario task compares against.
// -----------------------------------------------------------------------------
module tb_eth_rx_fcs_check;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic        CLK;
  logic        RESET;
  logic        IN_DV;
  logic [3:0]  IN_DATA;
  logic        OUT_SOF, OUT_VALID, OUT_EOF, OUT_FCS_OK, OUT_ALIGN_ERR, OUT_LEN_ERR;
  logic [7:0]  OUT_DATA;
  logic [10:0] OUT_LEN;
  logic [1:0]  OUT_DBG_STATE;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          sof_cnt;
  logic [10:0] eof_len_q[$];
  logic        eof_fcs_q[$];
  logic        eof_align_q[$];
  logic        eof_lenerr_q[$];

  eth_rx_fcs_check #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .CLK(CLK), .RESET(RESET), .IN_DV(IN_DV), .IN_DATA(IN_DATA),
    .OUT_SOF(OUT_SOF), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
    .OUT_EOF(OUT_EOF), .OUT_FCS_OK(OUT_FCS_OK), .OUT_ALIGN_ERR(OUT_ALIGN_ERR),
    .OUT_LEN_ERR(OUT_LEN_ERR), .OUT_LEN(OUT_LEN), .OUT_DBG_STATE(OUT_DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (OUT_SOF) sof_cnt++;
    if (OUT_VALID) got_q.push_back(OUT_DATA);
    if (OUT_EOF) begin
      eof_len_q.push_back(OUT_LEN);
      eof_fcs_q.push_back(OUT_FCS_OK);
      eof_align_q.push_back(OUT_ALIGN_ERR);
      eof_lenerr_q.push_back(OUT_LEN_ERR);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc32_ref(input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, tx_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic void build_frame(input int payload_n);
    logic [31:0] f;
    tx_q.delete();
    for (int i = 0; i < payload_n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    f = crc32_ref(payload_n);
    tx_q.push_back(f[7:0]);
    tx_q.push_back(f[15:8]);
    tx_q.push_back(f[23:16]);
    tx_q.push_back(f[31:24]);
  endfunction

  function automatic logic fcs_matches();
    int n = tx_q.size();
    if (n < 4) return 1'b0;
    return crc32_ref(n - 4) == {tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]};
  endfunction

  function automatic logic [10:0] exp_len(input int n);
    return (n > 2047) ? 11'h7FF : 11'(n);
  endfunction

  function automatic logic exp_len_err(input int n);
`ifdef RX_LEN_CHECK_EN
    return (int'(exp_len(n)) < MIN_LEN) || (int'(exp_len(n)) > MAX_LEN);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int byte_mismatches();
    int bad = 0;
    if (got_q.size() != exp_q.size()) return -1;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_mon();
    sof_cnt = 0;
    got_q.delete();
    exp_q.delete();
    eof_len_q.delete();
    eof_fcs_q.delete();
    eof_align_q.delete();
    eof_lenerr_q.delete();
  endtask

  task automatic drive(input logic dv, input logic [3:0] d);
    @(posedge CLK);
    #1;
    IN_DV   = dv;
    IN_DATA = d;
  endtask

  task automatic send_frame(input int pre_n, input bit extra);
    for (int i = 0; i < pre_n; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    foreach (tx_q[i]) begin
      drive(1'b1, tx_q[i][3:0]);
      drive(1'b1, tx_q[i][7:4]);
      exp_q.push_back(tx_q[i]);
    end
    if (extra) drive(1'b1, 4'hA);
    drive(1'b0, 4'h0);
  endtask

  task automatic wait_eof(input int n);
    for (int i = 0; i < 30 && eof_len_q.size() < n; i++) @(posedge CLK);
    repeat (2) @(posedge CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET = 1'b1; IN_DV = 1'b1; IN_DATA = 4'h5;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (OUT_SOF !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b expected 0", OUT_SOF); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", OUT_VALID); end
    checks++; if (OUT_DATA !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", OUT_DATA); end
    checks++; if (OUT_EOF !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b expected 0", OUT_EOF); end
    checks++; if (OUT_FCS_OK !== 1'b0) begin errors++; $display("FAIL reset_fcs_ok: got %b expected 0", OUT_FCS_OK); end
    checks++; if (OUT_ALIGN_ERR !== 1'b0) begin errors++; $display("FAIL reset_align: got %b expected 0", OUT_ALIGN_ERR); end
    checks++; if (OUT_LEN_ERR !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b expected 0", OUT_LEN_ERR); end
    checks++; if (OUT_LEN !== 11'd0) begin errors++; $display("FAIL reset_len: got %0d expected 0", OUT_LEN); end
    checks++; if (OUT_DBG_STATE !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", OUT_DBG_STATE); end
    IN_DV = 1'b0; IN_DATA = 4'h0;
    @(posedge CLK); #1; RESET = 1'b0;
    repeat (3) @(posedge CLK);
  endtask

  task automatic test_good_frame();
    int bad;
    clear_mon();
    build_frame(60);
    send_frame(15, 1'b0);
    wait_eof(1);
    bad = byte_mismatches();
    checks++; if (sof_cnt !== 1) begin errors++; $display("FAIL good_sof_count: got %0d expected 1", sof_cnt); end
    checks++; if (got_q.size() !== 64) begin errors++; $display("FAIL good_valid_count: got %0d expected 64", got_q.size()); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL good_bytes: got %0d mismatches expected 0", bad); end
    checks++; if (eof_len_q.size() !== 1) begin errors++; $display("FAIL good_eof_count: got %0d expected 1", eof_len_q.size()); end
    if (eof_len_q.size() == 1) begin
      checks++; if (eof_len_q[0] !== 11'd64) begin errors++; $display("FAIL good_len: got %0d expected 64", eof_len_q[0]); end
      checks++; if (eof_fcs_q[0] !== 1'b1) begin errors++; $display("FAIL good_fcs_ok: got %b expected 1", eof_fcs_q[0]); end
      checks++; if (eof_align_q[0] !== 1'b0) begin errors++; $display("FAIL good_align: got %b expected 0", eof_align_q[0]); end
      checks++; if (eof_lenerr_q[0] !== exp_len_err(64)) begin errors++; $display("FAIL good_len_err: got %b expected %b", eof_lenerr_q[0], exp_len_err(64)); end
    end
    // Status must still be held several cycles after the pulse.
    repeat (3) @(negedge CLK);
    checks++; if ({OUT_EOF, OUT_LEN, OUT_FCS_OK} !== {1'b0, 11'd64, 1'b1}) begin
      errors++; $display("FAIL good_hold: got eof=%b len=%0d ok=%b expected eof=0 len=64 ok=1", OUT_EOF, OUT_LEN, OUT_FCS_OK);
    end
  endtask

  task automatic test_bad_fcs();
    int k, b, bad;
    logic exp_ok;
    clear_mon();
    build_frame(60);
    k = $urandom_range(0, 59);
    b = $urandom_range(0, 7);
    tx_q[k] = tx_q[k] ^ (8'd1 << b);
    exp_ok = fcs_matches();
    send_frame(15, 1'b0);
    wait_eof(1);
    bad = byte_mismatches();
    checks++; if (bad !== 0) begin errors++; $display("FAIL badfcs_bytes: got %0d mismatches expected 0", bad); end
    checks++; if (eof_len_q.size() !== 1) begin errors++; $display("FAIL badfcs_eof_count: got %0d expected 1", eof_len_q.size()); end
    if (eof_len_q.size() == 1) begin
      checks++; if (eof_fcs_q[0] !== exp_ok) begin errors++; $display("FAIL badfcs_fcs_ok: got %b expected %b", eof_fcs_q[0], exp_ok); end
      checks++; if (eof_len_q[0] !== 11'd64) begin errors++; $display("FAIL badfcs_len: got %0d expected 64", eof_len_q[0]); end
    end
  endtask

  task automatic test_align();
    int bad;
    clear_mon();
    build_frame(60);
    send_frame(15, 1'b1);
    wait_eof(1);
    bad = byte_mismatches();
    checks++; if (bad !== 0) begin errors++; $display("FAIL align_bytes: got %0d mismatches expected 0", bad); end
    checks++; if (eof_len_q.size() !== 1) begin errors++; $display("FAIL align_eof_count: got %0d expected 1", eof_len_q.size()); end
    if (eof_len_q.size() == 1) begin
      checks++; if (eof_align_q[0] !== 1'b1) begin errors++; $display("FAIL align_err: got %b expected 1", eof_align_q[0]); end
      checks++; if (eof_len_q[0] !== 11'd64) begin errors++; $display("FAIL align_len: got %0d expected 64", eof_len_q[0]); end
    end
  endtask

  task automatic test_preamble_drop();
    clear_mon();
    drive(1'b1, 4'h5);
    drive(1'b1, 4'h5);
    drive(1'b1, 4'h3);
    drive(1'b1, 4'hD);
    for (int i = 0; i < 20; i++) drive(1'b1, 4'($urandom_range(0, 15)));
    drive(1'b0, 4'h0);
    repeat (6) @(posedge CLK);
    checks++; if (sof_cnt !== 0) begin errors++; $display("FAIL drop_sof: got %0d expected 0", sof_cnt); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL drop_valid: got %0d expected 0", got_q.size()); end
    checks++; if (eof_len_q.size() !== 0) begin errors++; $display("FAIL drop_eof: got %0d expected 0", eof_len_q.size()); end
  endtask

  task automatic test_lengths();
    int lens[6] = '{20, 63, 64, 1518, 1519, 2100};
    foreach (lens[j]) begin
      clear_mon();
      build_frame(lens[j] - 4);
      send_frame($urandom_range(1, 15), 1'b0);
      wait_eof(1);
      checks++; if (eof_len_q.size() !== 1) begin errors++; $display("FAIL len%0d_eof_count: got %0d expected 1", lens[j], eof_len_q.size()); end
      if (eof_len_q.size() == 1) begin
        checks++; if (eof_len_q[0] !== exp_len(lens[j])) begin errors++; $display("FAIL len%0d_len: got %0d expected %0d", lens[j], eof_len_q[0], exp_len(lens[j])); end
        checks++; if (eof_lenerr_q[0] !== exp_len_err(lens[j])) begin errors++; $display("FAIL len%0d_len_err: got %b expected %b", lens[j], eof_lenerr_q[0], exp_len_err(lens[j])); end
        checks++; if (eof_fcs_q[0] !== 1'b1) begin errors++; $display("FAIL len%0d_fcs_ok: got %b expected 1", lens[j], eof_fcs_q[0]); end
      end
    end
  endtask

  task automatic test_random_frames();
    int bad, n;
    bit extra;
    logic exp_ok;
    for (int f = 0; f < 8; f++) begin
      clear_mon();
      build_frame($urandom_range(10, 80));
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(0, tx_q.size() - 1);
        tx_q[n] = tx_q[n] ^ (8'd1 << $urandom_range(0, 7));
      end
      extra  = ($urandom_range(0, 3) == 0);
      exp_ok = fcs_matches();
      n      = tx_q.size();
      send_frame($urandom_range(1, 15), extra);
      wait_eof(1);
      bad = byte_mismatches();
      checks++; if (bad !== 0) begin errors++; $display("FAIL rand%0d_bytes: got %0d mismatches expected 0", f, bad); end
      checks++; if (sof_cnt !== 1) begin errors++; $display("FAIL rand%0d_sof: got %0d expected 1", f, sof_cnt); end
      checks++; if (eof_len_q.size() !== 1) begin errors++; $display("FAIL rand%0d_eof_count: got %0d expected 1", f, eof_len_q.size()); end
      if (eof_len_q.size() == 1) begin
        checks++; if (eof_len_q[0] !== exp_len(n)) begin errors++; $display("FAIL rand%0d_len: got %0d expected %0d", f, eof_len_q[0], exp_len(n)); end
        checks++; if (eof_align_q[0] !== extra) begin errors++; $display("FAIL rand%0d_align: got %b expected %b", f, eof_align_q[0], extra); end
        if (!extra) begin
          checks++; if (eof_fcs_q[0] !== exp_ok) begin errors++; $display("FAIL rand%0d_fcs_ok: got %b expected %b", f, eof_fcs_q[0], exp_ok); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    clear_mon();
    build_frame(30);
    send_frame(5, 1'b0);
    // Next preamble nibble lands on the cycle OUT_EOF of the first frame is high.
    build_frame(40);
    send_frame(9, 1'b0);
    wait_eof(2);
    bad = byte_mismatches();
    checks++; if (sof_cnt !== 2) begin errors++; $display("FAIL b2b_sof: got %0d expected 2", sof_cnt); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_bytes: got %0d mismatches expected 0", bad); end
    checks++; if (eof_len_q.size() !== 2) begin errors++; $display("FAIL b2b_eof_count: got %0d expected 2", eof_len_q.size()); end
    if (eof_len_q.size() == 2) begin
      checks++; if ({eof_len_q[0], eof_len_q[1]} !== {11'd34, 11'd44}) begin errors++; $display("FAIL b2b_len: got %0d,%0d expected 34,44", eof_len_q[0], eof_len_q[1]); end
      checks++; if ({eof_fcs_q[0], eof_fcs_q[1]} !== 2'b11) begin errors++; $display("FAIL b2b_fcs_ok: got %b%b expected 11", eof_fcs_q[0], eof_fcs_q[1]); end
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    clear_mon();
    build_frame(60);
    for (int i = 0; i < 7; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tx_q[i][3:0]);
      drive(1'b1, tx_q[i][7:4]);
    end
    @(posedge CLK); #1;
    RESET = 1'b1; IN_DATA = tx_q[10][3:0];
    @(negedge CLK);
    checks++; if ({OUT_SOF, OUT_VALID, OUT_DATA, OUT_EOF, OUT_FCS_OK, OUT_ALIGN_ERR, OUT_LEN_ERR, OUT_LEN} !== 24'd0) begin
      errors++; $display("FAIL midreset_outputs: got sof=%b valid=%b data=%h eof=%b len=%0d expected all 0", OUT_SOF, OUT_VALID, OUT_DATA, OUT_EOF, OUT_LEN);
    end
    clear_mon();
    drive(1'b1, 4'($urandom_range(0, 15)));
    drive(1'b1, 4'($urandom_range(0, 15)));
    @(posedge CLK); #1; RESET = 1'b0;
    // Line still active after release: looks like a preamble but must be ignored.
    drive(1'b1, 4'h5); drive(1'b1, 4'h5); drive(1'b1, 4'h5); drive(1'b1, 4'hD);
    for (int i = 0; i < 16; i++) drive(1'b1, 4'($urandom_range(0, 15)));
    drive(1'b0, 4'h0);
    repeat (8) @(posedge CLK);
    checks++; if (sof_cnt !== 0) begin errors++; $display("FAIL midreset_sof: got %0d expected 0", sof_cnt); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL midreset_valid: got %0d expected 0", got_q.size()); end
    checks++; if (eof_len_q.size() !== 0) begin errors++; $display("FAIL midreset_eof: got %0d expected 0", eof_len_q.size()); end
    clear_mon();
    build_frame(60);
    send_frame(15, 1'b0);
    wait_eof(1);
    bad = byte_mismatches();
    checks++; if (bad !== 0) begin errors++; $display("FAIL midreset_clean_bytes: got %0d mismatches expected 0", bad); end
    checks++; if (eof_len_q.size() !== 1) begin errors++; $display("FAIL midreset_clean_eof: got %0d expected 1", eof_len_q.size()); end
    if (eof_len_q.size() == 1) begin
      checks++; if ({eof_len_q[0], eof_fcs_q[0], eof_align_q[0]} !== {11'd64, 1'b1, 1'b0}) begin
        errors++; $display("FAIL midreset_clean_status: got len=%0d ok=%b align=%b expected len=64 ok=1 align=0", eof_len_q[0], eof_fcs_q[0], eof_align_q[0]);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    sof_cnt = 0;
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_align();
    test_preamble_drop();
    test_lengths();
    test_random_frames();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
